// File: rtl/jk_ff.sv
// -----------------------------------------------------------------------------
// jk_ff : bank of WIDTH independent positive-edge-triggered JK flip-flops
//
// Purpose
//   General-purpose sequential primitive for counters and control logic.
//   Every bit follows the classic JK truth table on the rising edge of Clk:
//     J K | next Q
//     0 0 | Q      (hold)
//     0 1 | 0      (reset)
//     1 0 | 1      (set)
//     1 1 | ~Q     (toggle)
//   The default WIDTH=1 is a drop-in single JK flip-flop.
//
// Parameters
//   WIDTH        number of independent JK bits (>= 1)
//   RESET_VALUE  value loaded into Q on reset and at power-up
//
// Ports
//   Clk   in   1      clock, all state changes on the rising edge
//   Rst   in   1      asynchronous, active-high reset (dominates J/K)
//   J     in   WIDTH  per-bit set control
//   K     in   WIDTH  per-bit reset control
//   Q     out  WIDTH  registered state
//   Qbar  out  WIDTH  bitwise complement of Q, derived from the same register
// -----------------------------------------------------------------------------
module jk_ff #(
  parameter int unsigned           WIDTH       = 1,
  parameter logic [WIDTH-1:0]      RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar
);

  // NOTE: the declaration initialiser gives a defined power-up state on
  // targets that support register init values; Rst is still the only
  // guaranteed way to reach RESET_VALUE on silicon.
  logic [WIDTH-1:0] state_q = RESET_VALUE;
  logic [WIDTH-1:0] state_next;

  // Characteristic equation of a JK flip-flop, evaluated bitwise:
  //   set when J is high and the bit is currently 0,
  //   keep a 1 unless K is high.
  // This covers all four truth-table rows, including toggle for J=K=1.
  always_comb begin
    state_next = (J & ~state_q) | (~K & state_q);
  end

  // NOTE: non-blocking assignment keeps every bit's update based on the
  // pre-edge value, so consecutive J=K=1 edges toggle exactly once each.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= RESET_VALUE;
    end else begin
      state_q <= state_next;
    end
  end

  // Single state register; Qbar has no storage of its own, so Qbar == ~Q
  // holds at all times, including during reset and at power-up.
  assign Q    = state_q;
  assign Qbar = ~state_q;

endmodule

// File: tb/tb_jk_ff.sv
// -----------------------------------------------------------------------------
// tb_jk_ff : self-checking bench for jk_ff
//
// Three instances share one 10 ns clock:
//   u0 : WIDTH=1, RESET_VALUE=0      (truth table, toggle, glitch, reset)
//   u1 : WIDTH=4, RESET_VALUE=0      (multi-bit independence)
//   u2 : WIDTH=4, RESET_VALUE=1010   (non-zero reset value)
// The stimulus process pushes hand-computed expectations into a queue and
// signals an observation point; a separate monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_jk_ff;

  typedef struct {
    string      name;
    int         unit;
    logic [3:0] q;
    logic [3:0] qbar;
  } exp_t;

  logic       clk;
  logic       rst0, rst1, rst2;
  logic [0:0] j0, k0, q0, qbar0;
  logic [3:0] j1, k1, q1, qbar1;
  logic [3:0] j2, k2, q2, qbar2;

  exp_t sb[$];
  event obs;
  int   checks = 0;
  int   errors = 0;

  jk_ff #(.WIDTH(1)) u0 (
    .Clk(clk), .Rst(rst0), .J(j0), .K(k0), .Q(q0), .Qbar(qbar0)
  );

  jk_ff #(.WIDTH(4)) u1 (
    .Clk(clk), .Rst(rst1), .J(j1), .K(k1), .Q(q1), .Qbar(qbar1)
  );

  jk_ff #(.WIDTH(4), .RESET_VALUE(4'b1010)) u2 (
    .Clk(clk), .Rst(rst2), .J(j2), .K(k2), .Q(q2), .Qbar(qbar2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Expected Q and Qbar are both given explicitly (hand-computed).
  task automatic push(input int unit, input string name, input logic [3:0] q, input logic [3:0] qbar);
    exp_t e;
    e.name = name;
    e.unit = unit;
    e.q    = q;
    e.qbar = qbar;
    sb.push_back(e);
  endtask

  // Monitor: pops every pending expectation at each observation point.
  initial begin
    exp_t       e;
    logic [3:0] aq, aqb;
    forever begin
      @(obs);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.unit)
          0:       begin aq = {3'b000, q0}; aqb = {3'b000, qbar0}; end
          1:       begin aq = q1;           aqb = qbar1;           end
          default: begin aq = q2;           aqb = qbar2;           end
        endcase
        check({e.name, ".q"},    aq,  e.q);
        check({e.name, ".qbar"}, aqb, e.qbar);
      end
    end
  end

  // Watchdog: the run must end on its own.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  // Wait for the next rising edge, then settle 1 ns before sampling.
  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] tt_jk [9];
  logic       tt_q  [9];

  initial begin
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    j0 = '0; k0 = '0; j1 = '0; k1 = '0; j2 = '0; k2 = '0;

    // Power-up state, Rst never asserted yet.
    #1;
    push(0, "pwr_u0", 4'b0000, 4'b0001);
    push(1, "pwr_u1", 4'b0000, 4'b1111);
    push(2, "pwr_u2", 4'b1010, 4'b0101);
    -> obs;

    // Single-bit truth-table sequence.
    tt_jk = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00};
    tt_q  = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      j0 = tt_jk[i][1];
      k0 = tt_jk[i][0];
      after_edge();
      push(0, $sformatf("tt%0d", i), {3'b000, tt_q[i]}, {3'b000, ~tt_q[i]});
      -> obs;
    end

    // Toggle divide-by-2 from Q=0.
    @(negedge clk);
    j0 = 1'b1; k0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      after_edge();
      push(0, $sformatf("tog%0d", i), (i % 2 == 0) ? 4'b0001 : 4'b0000,
           (i % 2 == 0) ? 4'b0000 : 4'b0001);
      -> obs;
    end

    // Hold with glitches on J and K between edges; Q must stay 1.
    @(negedge clk);
    j0 = 1'b1; k0 = 1'b0;
    after_edge();
    push(0, "set1", 4'b0001, 4'b0000);
    -> obs;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      j0 = 1'b0; k0 = 1'b0;
      #1 j0 = 1'b1;
      #1 j0 = 1'b0; k0 = 1'b1;
      #1 k0 = 1'b0;
      push(0, $sformatf("glitch_mid%0d", i), 4'b0001, 4'b0000);
      -> obs;
      after_edge();
      #1 k0 = 1'b1;
      #1 k0 = 1'b0; j0 = 1'b1;
      #1 j0 = 1'b0;
      push(0, $sformatf("glitch_hold%0d", i), 4'b0001, 4'b0000);
      -> obs;
    end

    // Asynchronous reset mid-cycle with J=1,K=0 and Q=1.
    @(negedge clk);
    j0 = 1'b1; k0 = 1'b0;
    #2 rst0 = 1'b1;
    #1;
    push(0, "rst_async", 4'b0000, 4'b0001);
    -> obs;
    for (int i = 0; i < 2; i++) begin
      after_edge();
      push(0, $sformatf("rst_hold%0d", i), 4'b0000, 4'b0001);
      -> obs;
    end
    @(negedge clk);
    rst0 = 1'b0;
    after_edge();
    push(0, "rst_release", 4'b0001, 4'b0000);
    -> obs;

    // Multi-bit independence on u1: reach 0101, then mixed J/K.
    @(negedge clk);
    j1 = 4'b0101; k1 = 4'b0000;
    after_edge();
    push(1, "mb_load", 4'b0101, 4'b1010);
    -> obs;
    @(negedge clk);
    j1 = 4'b1100; k1 = 4'b1010;
    after_edge();
    push(1, "mb_mixed", 4'b1101, 4'b0010);
    -> obs;
    @(negedge clk);
    j1 = 4'b1111; k1 = 4'b1111;
    after_edge();
    push(1, "mb_toggle", 4'b0010, 4'b1101);
    -> obs;

    // Non-zero RESET_VALUE on u2.
    @(negedge clk);
    j2 = 4'b0101; k2 = 4'b1010;
    after_edge();
    push(2, "rv_load", 4'b0101, 4'b1010);
    -> obs;
    @(negedge clk);
    j2 = 4'b0000; k2 = 4'b0000;
    #2 rst2 = 1'b1;
    #1;
    push(2, "rv_async", 4'b1010, 4'b0101);
    -> obs;
    @(negedge clk);
    rst2 = 1'b0;
    after_edge();
    push(2, "rv_first_edge", 4'b1010, 4'b0101);
    -> obs;

    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
